// File: rtl/pow_25519_if.sv
// pow_25519_if -- link between pow_25519 and a shared field multiplier.
//   mul_start : one-cycle request, driven by the exponentiator
//   mul_a/b   : operands, held stable while the request is pending
//   mul_res   : product mod p, valid while mul_done is high
//   mul_done  : one-cycle completion pulse from the multiplier
// master modport = exponentiator side, slave modport = multiplier side.
interface pow_25519_if;
  logic         mul_start;
  logic [254:0] mul_a;
  logic [254:0] mul_b;
  logic [254:0] mul_res;
  logic         mul_done;

  modport master (output mul_start, mul_a, mul_b, input mul_res, mul_done);
  modport slave  (input mul_start, mul_a, mul_b, output mul_res, mul_done);
endinterface

// File: rtl/pow_25519.sv
// pow_25519 -- modular exponentiation a^e mod p, p = 2^255-19, using MSB-first
// square-and-multiply on an external shared field multiplier.
// Ports:
//   clk, rst          : clock (rising edge) and synchronous active-high reset
//   start, mode       : request (sampled only in IDLE) and exponent source:
//                       0/3 = p-2 (inverse), 1 = (p-5)/8, 2 = external exp
//   a, exp            : base (already reduced mod p) and external exponent
//   res, done, busy   : result (held until next completion), one-cycle done
//                       pulse, and busy while not IDLE
//   mul               : multiplier bus (pow_25519_if.master)
// Build option: define POW25519_LEADING_SKIP_EN to skip leading zero exponent
// bits in SCAN (one bit per cycle) and start from result = base. The default
// build starts from result = 1 and processes every bit of the scan width.
module pow_25519 #(
  parameter int EXP_W = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [254:0]       a,
  input  logic [EXP_W-1:0]   exp,
  output logic [254:0]       res,
  output logic               done,
  output logic               busy,
  pow_25519_if.master        mul
);

  // E0 = 2^255-21 (p-2), E1 = 2^252-3 ((p-5)/8)
  localparam logic [254:0] E0      = {255{1'b1}} - 255'd20;
  localparam logic [254:0] E1      = (255'd1 << 252) - 255'd3;
  localparam logic [7:0]   IDX_EXT = 8'(EXP_W - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SCAN   = 3'd1,
    S_SQR    = 3'd2,
    S_MUL    = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t       state_q, state_d;
  logic [254:0] base_q, base_d;
  logic [254:0] exp_q, exp_d;
  logic [254:0] result_q, result_d;
  logic [254:0] res_q, res_d;
  logic [7:0]   idx_q, idx_d;
  // Set once the multiply of the current SQR/MUL visit has been issued; it
  // both makes mul_start a single pulse and gates acceptance of mul_done.
  logic         issued_q, issued_d;
  logic [254:0] exp_ext;

  assign exp_ext = 255'(exp);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      exp_q    <= '0;
      result_q <= '0;
      res_q    <= '0;
      idx_q    <= '0;
      issued_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      exp_q    <= exp_d;
      result_q <= result_d;
      res_q    <= res_d;
      idx_q    <= idx_d;
      issued_q <= issued_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    exp_d    = exp_q;
    result_d = result_q;
    res_d    = res_q;
    idx_d    = idx_q;
    issued_d = issued_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = a;
          case (mode)
            2'd1:    exp_d = E1;
            2'd2:    exp_d = exp_ext;
            default: exp_d = E0;
          endcase
          idx_d   = (mode == 2'd2) ? IDX_EXT : 8'd254;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
`ifdef POW25519_LEADING_SKIP_EN
        if (exp_q[idx_q]) begin
          // Leading one found: squaring 1 up to here would be wasted work.
          result_d = base_q;
          if (idx_q == 8'd0) begin
            state_d = S_FINISH;
          end else begin
            idx_d   = idx_q - 8'd1;
            state_d = S_SQR;
          end
        end else if (idx_q == 8'd0) begin
          result_d = 255'd1;
          state_d  = S_FINISH;
        end else begin
          idx_d = idx_q - 8'd1;
        end
`else
        result_d = 255'd1;
        // A zero exponent must not touch the multiplier at all.
        state_d  = (exp_q == '0) ? S_FINISH : S_SQR;
`endif
      end
      S_SQR, S_MUL: begin
        if (!issued_q) begin
          issued_d = 1'b1;
        end else if (mul.mul_done) begin
          issued_d = 1'b0;
          result_d = mul.mul_res;
          // After the square, a set bit still needs its multiply by base at
          // the same index; only then does the index move on.
          if (state_q == S_SQR && exp_q[idx_q]) begin
            state_d = S_MUL;
          end else if (idx_q == 8'd0) begin
            state_d = S_FINISH;
          end else begin
            idx_d   = idx_q - 8'd1;
            state_d = S_SQR;
          end
        end
      end
      S_FINISH: begin
        res_d   = result_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy          = (state_q != S_IDLE);
    done          = (state_q == S_FINISH);
    res           = res_q;
    mul.mul_start = 1'b0;
    mul.mul_a     = '0;
    mul.mul_b     = '0;
    if (state_q == S_SQR || state_q == S_MUL) begin
      // Operands come straight from registers that only change on the
      // accepted mul_done, so they are stable for the whole pending window.
      mul.mul_start = !issued_q;
      mul.mul_a     = result_q;
      mul.mul_b     = (state_q == S_SQR) ? result_q : base_q;
    end
  end

endmodule

// File: doc/pow_25519.md
POW_25519 -- requirements
Module: pow_25519

Interface
REQ-001 The module SHALL have one parameter: EXP_W, default 255, width of the external exponent (legal range 1..255).
REQ-002 Port clk, input, 1 bit: single clock; all logic on rising edge.
REQ-003 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 Port start, input, 1 bit: request; sampled only in IDLE.
REQ-005 Port mode, input, 2 bits: exponent source (0 = p-2 inverse, 1 = (p-5)/8 sqrt helper, 2 = external, 3 = treated as 0).
REQ-006 Port a, input, 255 bits: base, reduced mod p = 2^255-19.
REQ-007 Port exp, input, EXP_W bits: external exponent, used when mode=2.
REQ-008 Port res, output, 255 bits: a^e mod p.
REQ-009 Port done, output, 1 bit: one-cycle completion pulse.
REQ-010 Port busy, output, 1 bit: high whenever state != IDLE.
REQ-011 Port mul_start, output, 1 bit: one-cycle request to the shared field multiplier.
REQ-012 Port mul_a, output, 255 bits: multiplier operand A.
REQ-013 Port mul_b, output, 255 bits: multiplier operand B.
REQ-014 Port mul_res, input, 255 bits: multiplier product; valid when mul_done=1.
REQ-015 Port mul_done, input, 1 bit: one-cycle multiplier completion pulse.

Function
REQ-016 On start in IDLE, the block SHALL latch a, mode and exp (zero-extended to 255 bits) and set the scan width: 255 for modes 0/1/3, EXP_W for mode 2.
REQ-017 Internal constants SHALL be E0 = 2^255-21 and E1 = 2^252-3.
REQ-018 The state machine SHALL use states IDLE -> SCAN -> SQR <-> MUL -> FINISH -> IDLE, with MSB-first left-to-right square-and-multiply.
REQ-019 SQR SHALL compute result*result; if the current exponent bit is 1 it SHALL go to MUL, else decrement the bit index or go to FINISH at bit 0.
REQ-020 MUL SHALL compute result*base, then decrement the bit index or go to FINISH at bit 0.
REQ-021 Each multiplication SHALL issue mul_start exactly once, in the first cycle of the state.
REQ-022 mul_a/mul_b SHALL stay stable from issue until mul_done.
REQ-023 The state SHALL then wait for mul_done and SHALL NOT re-issue a start while a multiply is pending.
REQ-024 mul_start SHALL NOT assert in the cycle mul_done is sampled.
REQ-025 FINISH (1 cycle) SHALL load res and pulse done; res SHALL hold until the next FINISH.
REQ-026 start while busy SHALL be ignored, with no effect on the operation in flight.
REQ-027 Exponent zero SHALL give res = 1 with no mul_start issued.
REQ-028 a = 0 with a nonzero exponent SHALL give res = 0.
REQ-029 Latency from start to done SHALL be 2 + sum over issued multiplies of (L+1) cycles, where L = cycles from mul_start to mul_done, plus SCAN cycles.

Reset
REQ-030 While rst=1 at a clock edge the block SHALL return to IDLE from any state and clear res, done, busy, mul_start, mul_a, mul_b and the bit index to 0.
REQ-031 A mul_done arriving after a mid-operation reset SHALL be ignored.
REQ-032 The first start after reset release SHALL be accepted normally.

Configuration
REQ-033 The macro POW25519_LEADING_SKIP_EN SHALL control leading-zero skip.
REQ-034 With POW25519_LEADING_SKIP_EN defined, SCAN SHALL step one bit per cycle from the MSB to the first 1 bit, set result = base and begin at the next lower bit; an all-zero exponent SHALL go straight to FINISH with res = 1.
REQ-035 Without POW25519_LEADING_SKIP_EN, SCAN SHALL last one cycle, set result = 1 and process every bit of the scan width.
REQ-036 Final res SHALL be identical in both builds.

Verification
REQ-037 mode=0, a=2 -> res = 2^254-9 (0x3FFF...FFF7); done pulses exactly once.
REQ-038 mode=2, EXP_W=255, exp=3, a=5 -> res=125; mul_start count is 2 with POW25519_LEADING_SKIP_EN defined and 257 without it.
REQ-039 mode=2, exp=0, a=7 -> res=1, zero mul_start pulses; mode=0, a=0 -> res=0.
REQ-040 start re-asserted every cycle during a mode=0 run -> exactly one done, and res matches a single-run model.
REQ-041 rst pulsed mid-SQR, then a late mul_done -> stays IDLE with busy=0 and res=0; a new start with a=2, mode=0 completes correctly.
REQ-042 Model multiplier with L randomised 1..8 per operation -> results match the reference model and operands are stable during every pending multiply.
